// File: rtl/data_stream_byte_packer_if.sv
// Byte-strobed valid/ready stream bundle shared by packer input and output.
// Latency: none, wires only.
// Backpressure: the slave side drives ready and the master side holds its beat until ready.
interface ifc_data_stream_hs #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic                    valid;
  logic                    ready;

  modport master (output data, output strb, output valid, input ready);
  modport slave  (input data, input strb, input valid, output ready);
endinterface

// File: rtl/data_stream_byte_packer.sv
// Compacts sparse byte-strobed beats into dense full-width beats, with explicit flush of the tail.
// Latency: a byte accepted in cycle t is visible on the output from cycle t+1.
// Backpressure: s_ready is registered and only high when a whole input beat is guaranteed to fit.
module data_stream_byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  ifc_data_stream_hs.slave  s_if,
  ifc_data_stream_hs.master m_if,
  input  logic              flush,
  output logic              flush_done
);
  localparam int N  = DATA_WIDTH / 8;
  localparam int B  = 2 * N;
  localparam int CW = $clog2(B + 1);
  localparam int AW = $clog2(B);

  logic [B-1:0][7:0]       lanes_q, lanes_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic                    s_rdy_q, s_rdy_d;
  logic                    done_q, done_d;

  logic                    m_vld;
  logic [DATA_WIDTH-1:0]   m_dat;
  logic [N-1:0]            m_stb;
  logic                    in_hs;
  logic                    out_hs;
  logic                    flush_req;
  int                      rem;
  int                      wr_pos;

  // Present the low N lanes; lanes not yet occupied read as zero with strobe clear.
  always_comb begin
    m_vld = (int'(cnt_q) >= N) || (pend_q && (cnt_q != '0));
    m_dat = '0;
    m_stb = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(cnt_q)) begin
        m_dat[8*i +: 8] = lanes_q[i];
        m_stb[i]        = 1'b1;
      end
    end
  end

  assign m_if.valid = m_vld;
  assign m_if.data  = m_dat;
  assign m_if.strb  = m_stb;
  assign s_if.ready = s_rdy_q;
  assign flush_done = done_q;

  // Next state: drop the outgoing beat first, then append accepted bytes behind the remainder.
  always_comb begin
    in_hs  = s_if.valid && s_rdy_q;
    out_hs = m_vld && m_if.ready;
    rem    = 0;
    if (out_hs) begin
      rem = (int'(cnt_q) >= N) ? N : int'(cnt_q);
    end

    for (int i = 0; i < B; i++) begin
      lanes_d[i] = 8'h00;
      if (i + rem < B) begin
        lanes_d[i] = lanes_q[AW'(i + rem)];
      end
    end

    wr_pos = int'(cnt_q) - rem;
    if (in_hs) begin
      for (int j = 0; j < N; j++) begin
        if (s_if.strb[j]) begin
          if (wr_pos < B) begin
            lanes_d[AW'(wr_pos)] = s_if.data[8*j +: 8];
          end
          wr_pos = wr_pos + 1;
        end
      end
    end
    cnt_d = CW'(wr_pos);

    // A flush stays pending until the buffer is empty; a repeat request while pending is absorbed.
    flush_req = pend_q || flush;
    pend_d    = flush_req && (cnt_d != '0);
    done_d    = flush_req && (cnt_d == '0);
    s_rdy_d   = (int'(cnt_d) <= N) && !pend_d;
  end

  // State registers; reset discards anything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      s_rdy_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      s_rdy_q <= s_rdy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_data_stream_byte_packer.sv
// Bench for the byte packer: directed scenarios plus randomized traffic against a byte-queue model.
// Expected beats are queued when input is accepted; an output monitor pops and compares.
// Output stability under backpressure is checked continuously.
module tb_data_stream_byte_packer;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_done;

  ifc_data_stream_hs #(.DATA_WIDTH(32)) s_bus ();
  ifc_data_stream_hs #(.DATA_WIDTH(32)) m_bus ();

  data_stream_byte_packer #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (s_bus),
    .m_if       (m_bus),
    .flush      (flush),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  int         tests  = 0;
  int         fails  = 0;
  int         hs_cnt = 0;
  logic [7:0] mq[$];
  beat_t      eq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic emit(input int n);
    beat_t b;
    b.d = '0;
    b.s = '0;
    for (int i = 0; i < n; i++) begin
      b.d[8*i +: 8] = mq.pop_front();
      b.s[i]        = 1'b1;
    end
    eq.push_back(b);
  endtask

  // Reference model: accepted bytes queue up in order; every N bytes form a full beat, a flush emits the rest.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_bus.valid && s_bus.ready) begin
        for (int j = 0; j < N; j++) begin
          if (s_bus.strb[j]) mq.push_back(s_bus.data[8*j +: 8]);
        end
      end
      while (mq.size() >= N) emit(N);
      if (flush && mq.size() > 0) emit(mq.size());
    end
  end

  // Output monitor: compare each handshaked beat and check hold-while-stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d     = '0;
  logic [3:0]  prev_s     = '0;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_bus.valid), 32'd1);
        chk("hold_data", m_bus.data, prev_d);
        chk("hold_strb", 32'(m_bus.strb), 32'(prev_s));
      end
      if (m_bus.valid && m_bus.ready) begin
        hs_cnt++;
        if (eq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_beat: got beat 0x%0h, expected no beat", m_bus.data);
        end else begin
          b = eq.pop_front();
          chk("out_data", m_bus.data, b.d);
          chk("out_strb", 32'(m_bus.strb), 32'(b.s));
        end
      end
      prev_stall = m_bus.valid && !m_bus.ready;
      prev_d     = m_bus.data;
      prev_s     = m_bus.strb;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    s_bus.valid = ($urandom_range(0, 3) != 0);
    s_bus.data  = $urandom;
    s_bus.strb  = 4'($urandom);
    m_bus.ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    s_bus.valid = 1'b1;
    s_bus.data  = d;
    s_bus.strb  = s;
    sample();
    while (!s_bus.ready && t < 100) begin
      t++;
      sample();
    end
    if (!s_bus.ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready got 0, expected 1");
    end
    step();
    s_bus.valid = 1'b0;
  endtask

  task automatic flush_and_wait(input bit rnd);
    int t = 0;
    flush = 1'b1;
    sample();
    step();
    flush = 1'b0;
    if (rnd) randomize_inputs();
    sample();
    while (!flush_done && t < 200) begin
      t++;
      step();
      if (rnd) randomize_inputs();
      sample();
    end
    chk("flush_done", 32'(flush_done), 32'd1);
    if (flush_done) chk("flush_done_s_ready", 32'(s_bus.ready), 32'd1);
    step();
  endtask

  initial begin
    int base;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    s_bus.strb  = '0;
    m_bus.ready = 1'b0;

    // Reset values
    #1;
    chk("rst_s_ready", 32'(s_bus.ready), 32'd0);
    chk("rst_m_valid", 32'(m_bus.valid), 32'd0);
    chk("rst_m_data", m_bus.data, 32'd0);
    chk("rst_m_strb", 32'(m_bus.strb), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    repeat (2) sample();
    rst = 1'b0;
    step();
    chk("post_rst_s_ready", 32'(s_bus.ready), 32'd1);
    chk("post_rst_m_valid", 32'(m_bus.valid), 32'd0);

    // Two half beats pair into one full beat
    m_bus.ready = 1'b1;
    send(32'h0000_2211, 4'b0011);
    sample();
    chk("pair_half_valid", 32'(m_bus.valid), 32'd0);
    step();
    send(32'h0000_4433, 4'b0011);
    sample();
    chk("pair_valid", 32'(m_bus.valid), 32'd1);
    chk("pair_data", m_bus.data, 32'h4433_2211);
    step();

    // Sparse strobes compact with no gaps
    send(32'hDD00_BB00, 4'b1010);
    send(32'h0000_FF00, 4'b0010);
    send(32'h1100_0000, 4'b1000);
    sample();
    chk("sparse_data", m_bus.data, 32'h11FF_DDBB);
    chk("sparse_strb", 32'(m_bus.strb), 32'hF);
    step();
    sample();
    chk("sparse_empty", 32'(m_bus.valid), 32'd0);
    step();

    // Flush of a partial beat
    m_bus.ready = 1'b0;
    send(32'h0033_2211, 4'b0111);
    flush = 1'b1;
    sample();
    step();
    flush = 1'b0;
    sample();
    chk("fl_s_ready", 32'(s_bus.ready), 32'd0);
    chk("fl_m_valid", 32'(m_bus.valid), 32'd1);
    chk("fl_m_data", m_bus.data, 32'h0033_2211);
    chk("fl_m_strb", 32'(m_bus.strb), 32'h7);
    step();
    m_bus.ready = 1'b1;
    sample();
    step();
    sample();
    chk("fl_done_pulse", 32'(flush_done), 32'd1);
    chk("fl_s_ready_back", 32'(s_bus.ready), 32'd1);
    chk("fl_m_valid_off", 32'(m_bus.valid), 32'd0);
    step();
    sample();
    chk("fl_done_single", 32'(flush_done), 32'd0);
    step();

    // Flush with an empty buffer completes on the next cycle
    flush = 1'b1;
    sample();
    step();
    flush = 1'b0;
    sample();
    chk("empty_flush_done", 32'(flush_done), 32'd1);
    chk("empty_flush_s_ready", 32'(s_bus.ready), 32'd1);
    step();

    // Backpressure with more than N bytes buffered
    m_bus.ready = 1'b0;
    send(32'hAABB_CCDD, 4'b1111);
    send(32'h0000_00EE, 4'b0001);
    sample();
    chk("bp_s_ready", 32'(s_bus.ready), 32'd0);
    chk("bp_data", m_bus.data, 32'hAABB_CCDD);
    chk("bp_strb", 32'(m_bus.strb), 32'hF);
    repeat (3) begin
      step();
      sample();
    end
    step();
    m_bus.ready = 1'b1;
    sample();
    step();
    m_bus.ready = 1'b0;
    sample();
    chk("bp_release_s_ready", 32'(s_bus.ready), 32'd1);
    chk("bp_release_m_valid", 32'(m_bus.valid), 32'd0);
    step();
    m_bus.ready = 1'b1;
    flush_and_wait(1'b0);

    // Dense streaming: one beat per cycle in and out
    m_bus.ready = 1'b1;
    base = hs_cnt;
    for (int k = 0; k < 16; k++) begin
      s_bus.valid = 1'b1;
      s_bus.data  = $urandom;
      s_bus.strb  = 4'hF;
      sample();
      chk("stream_s_ready", 32'(s_bus.ready), 32'd1);
      step();
    end
    s_bus.valid = 1'b0;
    sample();
    step();
    sample();
    chk("stream_beats", 32'(hs_cnt - base), 32'd16);
    step();

    // Reset mid-stream with five bytes buffered
    m_bus.ready = 1'b0;
    send(32'hAABB_CCDD, 4'b1111);
    send(32'h0000_00EE, 4'b0001);
    rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", 32'(s_bus.ready), 32'd0);
    chk("mid_rst_m_valid", 32'(m_bus.valid), 32'd0);
    chk("mid_rst_m_data", m_bus.data, 32'd0);
    chk("mid_rst_m_strb", 32'(m_bus.strb), 32'd0);
    chk("mid_rst_flush_done", 32'(flush_done), 32'd0);
    mq.delete();
    eq.delete();
    sample();
    #1;
    rst = 1'b0;
    step();
    chk("mid_rst_s_ready_up", 32'(s_bus.ready), 32'd1);
    chk("mid_rst_m_valid_low", 32'(m_bus.valid), 32'd0);

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 1500; k++) begin
      randomize_inputs();
      if ($urandom_range(0, 39) == 0) begin
        flush_and_wait(1'b1);
      end else begin
        sample();
        step();
      end
    end
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    flush_and_wait(1'b0);
    sample();
    chk("final_beats_left", 32'(eq.size()), 32'd0);
    chk("final_bytes_left", 32'(mq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/data_stream_byte_packer.md
# data_stream_byte_packer

Compacts a handshaked byte-strobed data stream whose beats may carry sparse or partial strobes into a dense output stream of fully populated beats. Valid bytes are kept in lane order, lowest lane first, with no gaps. The block sits directly upstream of consumers that expect full-width words (e.g. AXI write-data generators, wide FIFOs). Its `s_*` ports connect to a `ifc_data_stream_hs` slave modport and its `m_*` ports to a master modport. An explicit flush emits a final partial beat.

## Interface
- `DATA_WIDTH`, 32: stream width in bits; multiple of 8, ≥ 16. `N = DATA_WIDTH/8` byte lanes.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  DATA_WIDTH  input beat data.
- `s_strb`  in  N  input byte enables; any pattern is legal, including all-zero.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready`.
- `m_data`  out  DATA_WIDTH  packed output data.
- `m_strb`  out  N  output byte enables; all-ones, or contiguous low lanes on a flush beat.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  output beat consumed when `m_valid & m_ready`.
- `flush`  in  1  single-cycle request to drain all buffered bytes.
- `flush_done`  out  1  one-cycle pulse when a flush has completed.

## Operation
- Internal state:
  - byte buffer of 2N lanes;
  - count `C`, range 0..2N, width `$clog2(2N+1)`;
  - `flush_pending` flag;
  - registered `s_ready`.
- Input accept: bytes of `s_data` with `s_strb[i]=1` are appended in ascending lane order at buffer position `C`, after any same-cycle output removal. A beat with all-zero strobe is accepted and adds nothing.
- `s_ready` (registered) = `(C_next <= N) & !flush_pending_next`. This guarantees room for a full input beat and gives no combinational path from `m_ready` or `s_valid`.
- Output:
  - `m_valid = (C >= N) | (flush_pending & C > 0)`.
  - `m_data` = buffer lanes 0..N-1. Lanes at or above `C` are driven 0.
  - `m_strb` = all-ones if `C >= N`, else low `C` bits set.
- On an output handshake, `min(C, N)` bytes are removed and the remaining bytes shift down by that amount.
- Simultaneous input and output handshake: remove first, then append. `C_next = C - removed + popcount(s_strb)`.
- Flush:
  - `flush` sets `flush_pending`. If `flush_pending` is already set, the new `flush` is ignored.
  - While pending, `s_ready` = 0. If the flush arrives in the same cycle as an accepted beat, that beat is included.
  - Full beats drain first, then one partial beat.
  - `flush_pending` clears and `flush_done` pulses in the cycle after the handshake that brings `C` to 0.
  - If `flush` arrives with `C=0` and no input is accepted that cycle, `flush_done` pulses the next cycle.
- Reset, asynchronous: `C`=0, buffer=0, `flush_pending`=0, `s_ready`=0, `m_valid`=0, `m_data`=0, `m_strb`=0, `flush_done`=0. Any bytes in flight are discarded.

## Timing
- All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
- Latency: a byte accepted in cycle t is visible on `m_data` from cycle t+1. It is presented as soon as N bytes have accumulated or a flush is pending.
- `s_ready` rises in the first clock edge after `rst` deassertion.
- Throughput:
  - Dense input (full strobes) with `m_ready`=1 sustains one beat per cycle in and out.
  - `C` stays ≤ 2N at all times.
- Handshake rules:
  - `m_data`, `m_strb` and `m_valid` hold stable while `m_valid & !m_ready`.
  - `m_valid` never drops without a handshake, unless `rst` is asserted.
- Backpressure: `m_ready`=0 with `C > N` forces `s_ready`=0 from the next cycle.

## Test plan
- Reset: assert `rst` mid-stream with `C`=5 → all outputs 0 immediately. After deassert, `s_ready`=1 at the first edge, `m_valid`=0.
- Pairing: `s_data`=0x00002211/`s_strb`=0011, then 0x00004433/0011 → one beat with `m_data`=0x44332211, `m_strb`=1111.
- Sparse compaction: 0xDD00BB00/1010, 0x0000FF00/0010, 0x11000000/1000 → `m_data`=0x11FFDDBB, `m_strb`=1111, `C`=0 afterwards.
- Flush partial: feed 0x00332211/0111, pulse `flush` → `s_ready`=0. Output `m_data`=0x00332211, `m_strb`=0111. `flush_done` pulses the cycle after the handshake, then `s_ready` returns to 1.
- Backpressure: `m_ready`=0, feed 0xAABBCCDD/1111 then 0x000000EE/0001 → `C`=5, `s_ready`=0, `m_data` stable at 0xAABBCCDD. Release `m_ready` → 0xAABBCCDD out, `C`=1, `s_ready`=1.
- Streaming: 16 consecutive beats with full strobes and `m_ready`=1 → 16 output beats, identical data, one per cycle, `s_ready` never drops.
